// File: rtl/in_port_pkg.sv
// Shared types and defaults for the CPU input-port producer.
package in_port_pkg;

    localparam int IN_PORT_DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_REL
    } in_port_state_t;

endpackage

// File: rtl/in_port_ctrl_sync2.sv
// Parameterised-width two-flop synchroniser with a synchronous reset value.
module sync2
    import in_port_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s_p0;
    logic [WIDTH-1:0] s_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_p0 <= RST_VAL;
            s_p1 <= RST_VAL;
        end else begin
            s_p0 <= d;
            s_p1 <= s_p0;
        end
    end

    assign q = s_p1;

endmodule

// File: rtl/in_port_ctrl.sv
// Debounced push-button capture of the switch bank with a ready/ack handshake to the CPU.
// Optional build macro IN_PORT_OVERRUN_EN adds a sticky overrun output.
module in_port_ctrl
    import in_port_pkg::*;
#(
    parameter int DATA_W          = IN_PORT_DATA_W_DEF,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_in,
    input  logic [DATA_W-1:0] sw_in,
    input  logic              rd_ack,
    output logic              ready_out,
`ifdef IN_PORT_OVERRUN_EN
    output logic              overrun,
`endif
    output logic [DATA_W-1:0] data_out
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              btn_p;
    logic              btn_s;
    logic [DATA_W-1:0] sw_s;

    in_port_state_t    state;
    in_port_state_t    state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              capture;
    logic              capture_p1;

    assign btn_p = (BTN_ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    // stage 0: bring button and switches into the clock domain
    sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_p),
        .q     (btn_s)
    );

    sync2 #(.WIDTH(DATA_W), .RST_VAL('0)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw_in),
        .q     (sw_s)
    );

    // stage 1: debounce FSM, capture pulse registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            capture_p1 <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            capture_p1 <= capture;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = DEB_PRESS;
                    cnt_nxt   = '0;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = HELD;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nxt = DEB_REL;
                    cnt_nxt   = '0;
                end
            end
            DEB_REL: begin
                if (btn_s) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // stage 2: holding register and handshake; a capture beats a same-cycle ack
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_out <= 1'b0;
            data_out  <= '0;
        end else if (capture_p1) begin
            ready_out <= 1'b1;
            data_out  <= sw_s;
        end else if (rd_ack) begin
            ready_out <= 1'b0;
        end
    end

`ifdef IN_PORT_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (capture_p1 && ready_out && !rd_ack) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_in_port_ctrl.sv
// Directed bench for in_port_ctrl with DEBOUNCE_CYCLES=4 and an active-low button.
module tb_in_port_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_in;
    logic [7:0] sw_in;
    logic       rd_ack;
    logic       ready_out;
    logic [7:0] data_out;
`ifdef IN_PORT_OVERRUN_EN
    logic       overrun;
`endif

    int errors = 0;
    int checks = 0;

    in_port_ctrl #(
        .DATA_W          (8),
        .DEBOUNCE_CYCLES (4),
        .BTN_ACTIVE_LOW  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .sw_in     (sw_in),
        .rd_ack    (rd_ack),
        .ready_out (ready_out),
`ifdef IN_PORT_OVERRUN_EN
        .overrun   (overrun),
`endif
        .data_out  (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        btn_in = 1'b1;
        rd_ack = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic press(input logic [7:0] sw, input int low, input int high);
        sw_in  = sw;
        btn_in = 1'b0;
        step(low);
        btn_in = 1'b1;
        step(high);
    endtask

    int         caps;
    logic [7:0] first_cap;
    logic       ready_seen;

    initial begin
        reset  = 1'b1;
        btn_in = 1'b1;
        sw_in  = 8'hA5;
        rd_ack = 1'b0;

        // basic latency and acknowledge
        do_reset();
        check("rst_ready", ready_out, 1'b0);
        check("rst_data", data_out, 8'h00);
`ifdef IN_PORT_OVERRUN_EN
        check("rst_overrun", overrun, 1'b0);
`endif
        btn_in = 1'b0;
        step(7);
        check("lat_not_before", ready_out, 1'b0);
        check("lat_data_before", data_out, 8'h00);
        step(1);
        check("lat_ready", ready_out, 1'b1);
        check("lat_data", data_out, 8'hA5);
        rd_ack = 1'b1;
        step(1);
        rd_ack = 1'b0;
        check("ack_ready", ready_out, 1'b0);
        check("ack_data_hold", data_out, 8'hA5);
        step(3);
        check("held_no_repeat", ready_out, 1'b0);
        btn_in = 1'b1;
        step(12);

        // bounce shorter than the debounce window
        do_reset();
        sw_in      = 8'h77;
        ready_seen = 1'b0;
        btn_in = 1'b0; step(2);
        btn_in = 1'b1; step(3);
        btn_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            ready_seen |= ready_out;
        end
        btn_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            ready_seen |= ready_out;
        end
        check("bounce_ready", ready_seen, 1'b0);
        check("bounce_data", data_out, 8'h00);

        // long hold then second press: exactly two captures
        do_reset();
        caps      = 0;
        first_cap = 8'h00;
        sw_in     = 8'h81;
        for (int i = 0; i < 60; i++) begin
            if (i == 0)  btn_in = 1'b0;
            if (i == 30) btn_in = 1'b1;
            if (i == 40) begin
                sw_in  = 8'h3C;
                btn_in = 1'b0;
            end
            step(1);
            if (ready_out && !rd_ack) begin
                caps++;
                if (caps == 1) first_cap = data_out;
                rd_ack = 1'b1;
            end else begin
                rd_ack = 1'b0;
            end
        end
        rd_ack = 1'b0;
        btn_in = 1'b1;
        step(12);
        check("hold_caps", caps, 2);
        check("hold_first", first_cap, 8'h81);
        check("hold_second", data_out, 8'h3C);

        // overrun: two presses, no ack
        do_reset();
        press(8'h11, 10, 10);
        check("ovr_first", data_out, 8'h11);
`ifdef IN_PORT_OVERRUN_EN
        check("ovr_flag_first", overrun, 1'b0);
`endif
        press(8'h22, 10, 10);
        check("ovr_ready", ready_out, 1'b1);
        check("ovr_data", data_out, 8'h22);
`ifdef IN_PORT_OVERRUN_EN
        check("ovr_flag", overrun, 1'b1);
`endif

        // ack on the exact capture edge of a second press
        do_reset();
        press(8'h11, 10, 10);
        sw_in  = 8'h5A;
        btn_in = 1'b0;
        step(7);
        check("race_pre_ready", ready_out, 1'b1);
        check("race_pre_data", data_out, 8'h11);
        rd_ack = 1'b1;
        step(1);
        rd_ack = 1'b0;
        check("race_ready", ready_out, 1'b1);
        check("race_data", data_out, 8'h5A);
`ifdef IN_PORT_OVERRUN_EN
        check("race_overrun", overrun, 1'b0);
`endif
        btn_in = 1'b1;
        step(12);

        // reset mid-debounce after an unread capture; button stays held
        do_reset();
        press(8'h11, 10, 10);
        check("mid_prior_ready", ready_out, 1'b1);
        sw_in  = 8'h66;
        btn_in = 1'b0;
        step(4);
        reset = 1'b1;
        step(1);
        check("mid_rst_ready", ready_out, 1'b0);
        check("mid_rst_data", data_out, 8'h00);
`ifdef IN_PORT_OVERRUN_EN
        check("mid_rst_overrun", overrun, 1'b0);
`endif
        reset = 1'b0;
        step(7);
        check("mid_not_before", ready_out, 1'b0);
        step(1);
        check("mid_fresh_ready", ready_out, 1'b1);
        check("mid_fresh_data", data_out, 8'h66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/in_port_ctrl.md
Name: in_port_ctrl

Overview:
- Producer side of the CPU input-port handshake.
- Synchronises and debounces a raw push-button, and captures the switch bank into a holding register on each clean press.
- Presents ready_out/data_out to the CPU, which consumes them through its ready_in/in_port inputs.
- The CPU returns a one-cycle rd_ack to clear ready.
- Sits at the top level between board pins and the CPU, in the CPU clock domain.

Parameters:
- DATA_W, 8, width of switch bank and data_out.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a press or release; must be >= 2.
- BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- btn_in  in  1  raw asynchronous push-button.
- sw_in  in  DATA_W  raw asynchronous switch bank.
- rd_ack  in  1  CPU read strobe; one cycle; meaningful only while ready_out=1.
- ready_out  out  1  data_out holds an unread capture.
- data_out  out  DATA_W  last captured switch value.

Behaviour:
- Reset: synchronous and active-high, single clock domain.
  - On any reset edge: ready_out=0, data_out=0, state=IDLE, debounce counter=0.
  - Synchroniser flops load the not-pressed level and sw=0.
- Reset mid-operation (any state) aborts it with no capture.
  - A button still held after reset is treated as a fresh press.
- Synchronisation:
  - btn_in is polarity-corrected to btn_p (1 = pressed) via BTN_ACTIVE_LOW.
  - btn_p and sw_in pass through a 2-flop synchroniser, giving btn_s and sw_s.
- Debounce FSM, states IDLE, DEB_PRESS, HELD, DEB_REL:
  - IDLE: if btn_s=1, go to DEB_PRESS with cnt=0.
  - DEB_PRESS:
    - btn_s=0: go to IDLE.
    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD and assert capture for this cycle.
    - Otherwise cnt++.
  - HELD: if btn_s=0, go to DEB_REL with cnt=0. No further capture while held (no auto-repeat).
  - DEB_REL:
    - btn_s=1: go to HELD.
    - btn_s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
    - Otherwise cnt++.
  - Counter width is $clog2(DEBOUNCE_CYCLES); it never wraps.
- Latency: with btn_in held pressed from sampling edge E, ready_out and the new data_out are visible after edge E+DEBOUNCE_CYCLES+3.
- Capture edge: data_out <= sw_s; ready_out <= 1.
- Handshake:
  - rd_ack while ready_out=1 clears ready_out at the next edge.
  - rd_ack while ready_out=0 is ignored.
  - data_out holds its value after ack until the next capture.
- Simultaneous capture and rd_ack: capture wins. ready_out stays 1 and data_out takes the new value.
- Capture while ready_out=1 with no ack (overrun): newest wins, so data_out is overwritten and ready_out stays 1.

Optional Feature:
- Macro IN_PORT_OVERRUN_EN.
- Defined:
  - Adds port overrun (out, 1).
  - overrun is set at the edge of any capture where ready_out=1 and rd_ack=0.
  - It is sticky and cleared only by reset; reset value is 0.
- Undefined:
  - No overrun port and no flag register.
  - Overwrite behaviour is identical.

Decomposition:
- Package in_port_pkg holds:
  - enum in_port_state_t {IDLE, DEB_PRESS, HELD, DEB_REL};
  - localparam IN_PORT_DATA_W_DEF = 8.
- One sub-module, sync2: parameterised-width 2-flop synchroniser with synchronous reset value parameter.
  - Instantiated twice: button at 1 bit with reset to not-pressed, switches at DATA_W with reset to 0.

Test Plan (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1):
- Reset, sw_in=0xA5, btn_in driven 0 from edge E and held -> ready_out=1 and data_out=0xA5 after edge E+7 (not before); one-cycle rd_ack -> ready_out=0 next edge and data_out stays 0xA5.
- Bounce: btn_in low 2 cycles, high 3, low 3, high -> ready_out never asserts and data_out stays 0.
- Hold btn_in low 30 cycles, release 10 cycles, press again with sw_in=0x3C -> exactly two captures; second gives data_out=0x3C.
- Two clean presses (0x11 then 0x22) with no rd_ack -> ready_out=1, data_out=0x22, and overrun=1 when IN_PORT_OVERRUN_EN is defined.
- rd_ack asserted on the exact capture edge of a second press (sw 0x5A) -> ready_out remains 1, data_out=0x5A, overrun stays 0.
- reset pulsed while in DEB_PRESS after a prior unread capture -> next edge ready_out=0, data_out=0, overrun=0; button still held -> fresh capture 7 edges after reset deasserts.
